// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Staged reset release after PLL lock. video_rst drops once lock has been
//   stable for HOLD_CYCLES. cpu_rst and ready follow CPU_DELAY cycles later.
//   Any loss of lock returns to full reset and is counted for debug.
//   In the run state a phase accumulator produces the fractional CPU clock
//   enable, at a rate of clock_in * CE_NUM / CE_DEN.
//
// Ports
//   clock_in       PLL output clock (the only clock)
//   rst_in         synchronous active-high reset
//   locked_in      PLL lock, already synchronous to clock_in
//   video_rst      active-high reset, video subsystem
//   cpu_rst        active-high reset, CPU and memory
//   cpu_ce         single-cycle CPU clock-enable pulse
//   ready          high once the sequence has completed
//   lock_loss_cnt  saturating count of lock-loss events
module clk_rst_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CPU_DELAY   = 256,
    parameter int unsigned CE_NUM      = 384,
    parameter int unsigned CE_DEN      = 3125
) (
    input  logic       clock_in,
    input  logic       rst_in,
    input  logic       locked_in,
    output logic       video_rst,
    output logic       cpu_rst,
    output logic       cpu_ce,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > CPU_DELAY) ? HOLD_CYCLES : CPU_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ACC_W   = $clog2(CE_DEN + CE_NUM);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(CPU_DELAY - 1);
    localparam logic [ACC_W-1:0] ACC_NUM    = ACC_W'(CE_NUM);
    localparam logic [ACC_W-1:0] ACC_DEN    = ACC_W'(CE_DEN);

    typedef enum logic [1:0] {
        S_WAIT,
        S_HOLD,
        S_VID,
        S_RUN
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ACC_W-1:0] acc, acc_nx, acc_sum;
    logic             video_rst_nx, cpu_rst_nx, cpu_ce_nx, ready_nx;
    logic [7:0]       lock_loss_cnt_nx;

    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        acc_nx           = acc;
        video_rst_nx     = video_rst;
        cpu_rst_nx       = cpu_rst;
        ready_nx         = ready;
        cpu_ce_nx        = 1'b0;
        lock_loss_cnt_nx = lock_loss_cnt;
        // acc < CE_DEN always, so the sum cannot overflow ACC_W bits.
        acc_sum          = acc + ACC_NUM;

        case (state)
            S_WAIT: begin
                video_rst_nx = 1'b1;
                cpu_rst_nx   = 1'b1;
                ready_nx     = 1'b0;
                cnt_nx       = '0;
                acc_nx       = '0;
                if (locked_in) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nx     = S_VID;
                    cnt_nx       = '0;
                    video_rst_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_VID: begin
                if (cnt == DELAY_LAST) begin
                    state_nx   = S_RUN;
                    cnt_nx     = '0;
                    cpu_rst_nx = 1'b0;
                    ready_nx   = 1'b1;
                    acc_nx     = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (acc_sum >= ACC_DEN) begin
                    acc_nx    = acc_sum - ACC_DEN;
                    cpu_ce_nx = 1'b1;
                end else begin
                    acc_nx = acc_sum;
                end
            end
            default: state_nx = S_WAIT;
        endcase

        // Lock loss outside S_WAIT overrides whatever the state decided above.
        if (!locked_in && state != S_WAIT) begin
            state_nx         = S_WAIT;
            cnt_nx           = '0;
            acc_nx           = '0;
            video_rst_nx     = 1'b1;
            cpu_rst_nx       = 1'b1;
            ready_nx         = 1'b0;
            cpu_ce_nx        = 1'b0;
            lock_loss_cnt_nx = (lock_loss_cnt == 8'hFF) ? 8'hFF : lock_loss_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state         <= S_WAIT;
            cnt           <= '0;
            acc           <= '0;
            video_rst     <= 1'b1;
            cpu_rst       <= 1'b1;
            cpu_ce        <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            acc           <= acc_nx;
            video_rst     <= video_rst_nx;
            cpu_rst       <= cpu_rst_nx;
            cpu_ce        <= cpu_ce_nx;
            ready         <= ready_nx;
            lock_loss_cnt <= lock_loss_cnt_nx;
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer
//   Bench for clk_rst_sequencer with HOLD_CYCLES=16, CPU_DELAY=8 and the
//   default 384/3125 clock-enable ratio.
module tb_clk_rst_sequencer;

    localparam int unsigned HOLD = 16;
    localparam int unsigned DLY  = 8;
    localparam longint      NUM  = 384;
    localparam longint      DEN  = 3125;

    logic       clock_in = 1'b0;
    logic       rst_in   = 1'b1;
    logic       locked_in = 1'b0;
    logic       video_rst, cpu_rst, cpu_ce, ready;
    logic [7:0] lock_loss_cnt;

    clk_rst_sequencer #(
        .HOLD_CYCLES(HOLD),
        .CPU_DELAY  (DLY),
        .CE_NUM     (384),
        .CE_DEN     (3125)
    ) dut (
        .clock_in     (clock_in),
        .rst_in       (rst_in),
        .locked_in    (locked_in),
        .video_rst    (video_rst),
        .cpu_rst      (cpu_rst),
        .cpu_ce       (cpu_ce),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_errors = 0;

    // Independent model: m_len counts consecutive locked edges since the last
    // reset or loss. Every output follows from m_len alone.
    int          m_len = 0;
    int          m_llc = 0;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] pack(input logic v, input logic c, input logic r,
                                         input logic e, input int llc);
        return {v, c, r, e, 8'(llc)};
    endfunction

    function automatic logic [11:0] model_out();
        logic   v, c, e;
        longint k;
        v = (m_len <= HOLD);
        c = (m_len <= HOLD + DLY);
        k = longint'(m_len) - longint'(HOLD + DLY + 1);
        e = (k >= 1) && ((k * NUM) / DEN > ((k - 1) * NUM) / DEN);
        return pack(v, c, !c, e, m_llc);
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got vid=%b cpu=%b rdy=%b ce=%b llc=%0d, expected vid=%b cpu=%b rdy=%b ce=%b llc=%0d",
                     name, $time, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {video_rst, cpu_rst, ready, cpu_ce, lock_loss_cnt};
    endfunction

    // One clock: drive inputs, push the model's prediction for the coming edge,
    // then pop it and compare once the DUT has produced that edge's outputs.
    task automatic tick(input logic r, input logic l);
        logic [11:0] e;
        rst_in    = r;
        locked_in = l;
        if (r) begin
            m_len = 0;
            m_llc = 0;
        end else if (l) begin
            m_len++;
        end else if (m_len > 0) begin
            m_len = 0;
            m_llc = (m_llc == 255) ? 255 : m_llc + 1;
        end
        exp_q.push_back(model_out());
        @(posedge clock_in);
        @(negedge clock_in);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty at %0t: got empty queue, expected one entry", $time);
        end else begin
            e = exp_q.pop_front();
            check("sb", dut_out(), e);
        end
    endtask

    task automatic run_sequence(input string tag, input int llc);
        repeat (HOLD) tick(1'b0, 1'b1);
        check({tag, "_hold_end"}, dut_out(), pack(1, 1, 0, 0, llc));
        tick(1'b0, 1'b1);
        check({tag, "_vid_release"}, dut_out(), pack(0, 1, 0, 0, llc));
        repeat (DLY - 1) tick(1'b0, 1'b1);
        check({tag, "_delay_end"}, dut_out(), pack(0, 1, 0, 0, llc));
        tick(1'b0, 1'b1);
        check({tag, "_cpu_release"}, dut_out(), pack(0, 0, 1, 0, llc));
    endtask

    typedef struct {
        logic        rst;
        logic        locked;
        int unsigned cycles;
        logic [11:0] exp;
    } vec_t;

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vecs[6];
        int   pulses, first, adj;
        logic prev;

        vecs[0] = '{1'b1, 1'b0, 4,   pack(1, 1, 0, 0, 0)};
        vecs[1] = '{1'b0, 1'b0, 100, pack(1, 1, 0, 0, 0)};
        vecs[2] = '{1'b0, 1'b1, 16,  pack(1, 1, 0, 0, 0)};
        vecs[3] = '{1'b0, 1'b1, 1,   pack(0, 1, 0, 0, 0)};
        vecs[4] = '{1'b0, 1'b1, 7,   pack(0, 1, 0, 0, 0)};
        vecs[5] = '{1'b0, 1'b1, 1,   pack(0, 0, 1, 0, 0)};

        @(negedge clock_in);
        for (int i = 0; i < 6; i++) begin
            for (int unsigned c = 0; c < vecs[i].cycles; c++) tick(vecs[i].rst, vecs[i].locked);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // cpu_ce rate from the first S_RUN edge.
        pulses = 0; first = 0; adj = 0; prev = 1'b0;
        for (int t = 1; t <= 31250; t++) begin
            tick(1'b0, 1'b1);
            if (cpu_ce) begin
                pulses++;
                if (first == 0) first = t;
                if (prev) adj++;
            end
            prev = cpu_ce;
            if (t == 3125) begin
                check("ce_count_3125", 12'(pulses), 12'd384);
                check("ce_first_edge", 12'(first), 12'd9);
            end
        end
        check("ce_count_31250", 12'(pulses), 12'd3840);
        check("ce_adjacent", 12'(adj), 12'd0);

        // One-cycle drop in S_HOLD with cnt=10.
        tick(1'b1, 1'b0);
        check("rst_pulse", dut_out(), pack(1, 1, 0, 0, 0));
        repeat (11) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("hold_glitch", dut_out(), pack(1, 1, 0, 0, 1));
        run_sequence("rerun1", 1);

        // One-cycle drop in S_RUN.
        repeat (20) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("run_drop", dut_out(), pack(1, 1, 0, 0, 2));
        run_sequence("rerun2", 2);

        // Reset on the same edge as a lock drop: reset wins.
        repeat (5) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        check("rst_beats_drop", dut_out(), pack(1, 1, 0, 0, 0));
        run_sequence("after_rst", 0);

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
        end
        check("llc_saturate", 12'(lock_loss_cnt), 12'd255);
        tick(1'b1, 1'b0);
        check("llc_cleared", 12'(lock_loss_cnt), 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
